cp0_regs: RTL and testbench
===========================

# cp0_regs

Coprocessor-0 register block for the multi-cycle MIPS core. It sits directly downstream of the core's control FSM and holds the Status, Cause, EPC, Count and Compare registers. It services mfc0/mtc0 accesses and performs the atomic register updates for exception entry and eret. It also produces the gated keyboard and timer interrupt requests that the FSM samples in its fetch state.

## Interface
- HANDLER_ADDR, 32'h0000_0180, exception handler entry address driven on handler_addr
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cp0_we  in  1  mtc0 write strobe
- cp0_addr  in  5  CP0 register number (rd field)
- cp0_wdata  in  32  mtc0 data (rt value)
- cp0_rdata  out  32  mfc0 read data, combinational from cp0_addr
- exc_entry  in  1  one-cycle pulse: commit exception entry
- exc_code  in  5  ExcCode for exc_entry (0 int, 8 syscall, 10 reserved instr, 12 overflow)
- epc_in  in  32  return address captured on exc_entry
- eret  in  1  one-cycle pulse: return from exception
- hw_int  in  1  keyboard interrupt level, asynchronous to clk
- int_kbd  out  1  gated keyboard request to control FSM
- int_cnt  out  1  gated timer request to control FSM
- epc_out  out  32  current EPC, feeds PC mux for eret
- handler_addr  out  32  constant HANDLER_ADDR
- status_out  out  32  current Status, for debug display

## Operation
- Register map:
  - 9 Count
  - 11 Compare
  - 12 Status
  - 13 Cause
  - 14 EPC
  - any other address reads 0; writes to it are ignored.
- Status fields:
  - bit0 IE, bit1 EXL, bits11:10 IM[1:0]; all other bits read 0 and are not writable.
  - Reset value 0.
- Cause fields:
  - bits6:2 ExcCode
  - bit10 IP0 (keyboard, synchronised level)
  - bit11 IP1 (timer pending, sticky)
  - all other bits 0; reset value 0.
  - mtc0 to Cause writes ExcCode only; IP bits are read-only.
- EPC: all 32 bits writable, reset 0.
- Count:
  - Reset 0; increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
  - An mtc0 to Count loads cp0_wdata with no increment that cycle.
- Compare: reset 0.
  - Timer match: Count==Compare with Compare!=0 sets IP1 at the next edge.
  - An mtc0 to Compare clears IP1, and the clear wins over a same-cycle match.
- hw_int passes through a two-flop synchroniser; the second flop output is IP0.
- Interrupt outputs:
  - int_kbd = IP0 & IM0 & IE & ~EXL
  - int_cnt = IP1 & IM1 & IE & ~EXL
  - both are combinational from registers.
- exc_entry: EPC<=epc_in, ExcCode<=exc_code, EXL<=1; IE and IM unchanged.
- eret: EXL<=0; all other fields unchanged.
- Update priority, highest first: reset > exc_entry > eret > cp0_we.
  - In a cycle with exc_entry or eret, any cp0_we is discarded.
  - exc_entry together with eret: exc_entry wins and EXL ends at 1.
- Count keeps incrementing through exc_entry and eret cycles.
- Reset outputs: cp0_rdata reads 0 for every register except Count, which counts from 0 after reset deasserts. int_kbd=0, int_cnt=0, epc_out=0, status_out=0.

## Timing
- Reads: cp0_rdata is valid in the same cycle as cp0_addr. A read in the same cycle as a write to that register returns the old value.
- Writes: visible on the cycle after the cp0_we edge.
- Keyboard: hw_int rising -> IP0 high 2 edges later -> int_kbd high in that cycle if enabled.
- Timer: a match at edge N-1 state sets IP1 at edge N; int_cnt is high during the cycle after edge N.
- exc_entry at edge N: EXL=1 and int_kbd/int_cnt drop in the cycle after N.
- eret at edge N: EXL=0 after N; a still-pending IP re-raises its request that cycle.
- Reset mid-operation clears all registers at the next edge, including the synchroniser flops, regardless of exc_entry, eret or cp0_we.

## Test plan
- Reset then mtc0 Status=32'h0000_0C03 -> read 12 gives 32'h0000_0C03. Write 32'hFFFF_FFFF -> reads 32'h0000_0C03.
- Status=32'h401 (IM0, IE), raise hw_int -> int_kbd high exactly 2 edges later. exc_entry with epc_in=32'h0000_0040, exc_code=0 -> EPC=32'h40, Cause=32'h400, EXL=1, int_kbd=0. eret -> int_kbd returns to 1 while hw_int stays high.
- Status=32'h801, Compare=32'd20, Count=32'd10 -> IP1 and int_cnt set 11 edges after the Count write. mtc0 Compare=0 -> IP1 cleared next cycle and stays clear.
- Count=32'hFFFF_FFFE -> reads FFFF_FFFF, then 0, then 1 on successive cycles.
- Same-cycle exc_entry (exc_code=8, epc_in=32'h100) with cp0_we to EPC=32'h200 -> EPC=32'h100, ExcCode=8. Same-cycle exc_entry and eret -> EXL=1.
- Assert reset while EXL=1 and IP1=1 -> next cycle Status=0, Cause=0, EPC=0, int_cnt=0, Count restarts from 0.

Source files
------------

// File: rtl/cp0_regs_if.sv
// mtc0/mfc0 access bus between the core's control FSM (master) and the CP0 register block (slave).
interface cp0_regs_if;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;

    modport master (
        output cp0_we,
        output cp0_addr,
        output cp0_wdata,
        input  cp0_rdata
    );

    modport slave (
        input  cp0_we,
        input  cp0_addr,
        input  cp0_wdata,
        output cp0_rdata
    );
endinterface

// File: rtl/cp0_regs.sv
// Coprocessor-0 register block: Status/Cause/EPC/Count/Compare, exception entry/eret updates,
// and gated keyboard/timer interrupt requests for the control FSM.
module cp0_regs #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        reset,
    cp0_regs_if.slave   bus,
    input  logic        exc_entry,
    input  logic [4:0]  exc_code,
    input  logic [31:0] epc_in,
    input  logic        eret,
    input  logic        hw_int,
    output logic        int_kbd,
    output logic        int_cnt,
    output logic [31:0] epc_out,
    output logic [31:0] handler_addr,
    output logic [31:0] status_out
);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    logic        ie_reg;
    logic        exl_reg;
    logic [1:0]  im_reg;
    logic [4:0]  exc_code_reg;
    logic        ip1_reg;
    logic [1:0]  sync_reg;
    logic [31:0] epc_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;

    logic        ip0;
    logic        wr_ok;
    logic        timer_hit;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    assign ip0        = sync_reg[1];
    // exc_entry and eret own the cycle; a concurrent mtc0 is dropped.
    assign wr_ok      = bus.cp0_we & ~exc_entry & ~eret;
    assign timer_hit  = (count_reg == compare_reg) && (compare_reg != 32'd0);
    assign status_val = {20'd0, im_reg, 8'd0, exl_reg, ie_reg};
    assign cause_val  = {20'd0, ip1_reg, ip0, 3'd0, exc_code_reg, 2'd0};

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_reg       <= 1'b0;
            exl_reg      <= 1'b0;
            im_reg       <= 2'b00;
            exc_code_reg <= 5'd0;
            ip1_reg      <= 1'b0;
            sync_reg     <= 2'b00;
            epc_reg      <= 32'd0;
            count_reg    <= 32'd0;
            compare_reg  <= 32'd0;
        end else begin
            sync_reg <= {sync_reg[0], hw_int};

            if (wr_ok && bus.cp0_addr == ADDR_COUNT)
                count_reg <= bus.cp0_wdata;
            else
                count_reg <= count_reg + 32'd1;

            // Writing Compare acknowledges the timer, even against a same-cycle match.
            if (wr_ok && bus.cp0_addr == ADDR_COMPARE)
                ip1_reg <= 1'b0;
            else if (timer_hit)
                ip1_reg <= 1'b1;

            if (exc_entry) begin
                epc_reg      <= epc_in;
                exc_code_reg <= exc_code;
                exl_reg      <= 1'b1;
            end else if (eret) begin
                exl_reg <= 1'b0;
            end else if (bus.cp0_we) begin
                case (bus.cp0_addr)
                    ADDR_COMPARE: compare_reg <= bus.cp0_wdata;
                    ADDR_STATUS: begin
                        ie_reg  <= bus.cp0_wdata[0];
                        exl_reg <= bus.cp0_wdata[1];
                        im_reg  <= bus.cp0_wdata[11:10];
                    end
                    ADDR_CAUSE:   exc_code_reg <= bus.cp0_wdata[6:2];
                    ADDR_EPC:     epc_reg <= bus.cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.cp0_rdata = 32'd0;
        case (bus.cp0_addr)
            ADDR_COUNT:   bus.cp0_rdata = count_reg;
            ADDR_COMPARE: bus.cp0_rdata = compare_reg;
            ADDR_STATUS:  bus.cp0_rdata = status_val;
            ADDR_CAUSE:   bus.cp0_rdata = cause_val;
            ADDR_EPC:     bus.cp0_rdata = epc_reg;
            default:      bus.cp0_rdata = 32'd0;
        endcase
    end

    assign int_kbd      = ip0 & im_reg[0] & ie_reg & ~exl_reg;
    assign int_cnt      = ip1_reg & im_reg[1] & ie_reg & ~exl_reg;
    assign epc_out      = epc_reg;
    assign handler_addr = HANDLER_ADDR;
    assign status_out   = status_val;
endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed scenarios plus randomized traffic against a register-level model.
module tb_cp0_regs;
    logic        clk = 1'b0;
    logic        reset;
    logic        exc_entry;
    logic [4:0]  exc_code;
    logic [31:0] epc_in;
    logic        eret;
    logic        hw_int;
    logic        int_kbd;
    logic        int_cnt;
    logic [31:0] epc_out;
    logic [31:0] handler_addr;
    logic [31:0] status_out;

    int checks = 0;
    int errors = 0;

    cp0_regs_if bus ();

    cp0_regs dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .exc_entry    (exc_entry),
        .exc_code     (exc_code),
        .epc_in       (epc_in),
        .eret         (eret),
        .hw_int       (hw_int),
        .int_kbd      (int_kbd),
        .int_cnt      (int_cnt),
        .epc_out      (epc_out),
        .handler_addr (handler_addr),
        .status_out   (status_out)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of the registers.
    logic [31:0] m_status, m_epc, m_count, m_compare;
    logic [4:0]  m_exccode;
    logic        m_ip1;
    logic        m_hw_seen [$];   // hw_int as sampled at each edge, newest at the back

    function automatic logic m_ip0();
        if (m_hw_seen.size() < 2) return 1'b0;
        return m_hw_seen[m_hw_seen.size()-2];
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_ip1) << 11) | (32'(m_ip0()) << 10) | (32'(m_exccode) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_enabled(input int im_bit);
        return m_status[im_bit] && m_status[0] && !m_status[1];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit wr, hit;
        if (reset) begin
            m_status = 0; m_epc = 0; m_count = 0; m_compare = 0;
            m_exccode = 0; m_ip1 = 0;
            m_hw_seen.delete();
            return;
        end
        wr  = bus.cp0_we && !exc_entry && !eret;
        hit = (m_count == m_compare) && (m_compare != 0);
        m_hw_seen.push_back(hw_int);
        if (m_hw_seen.size() > 2) void'(m_hw_seen.pop_front());
        if (wr && bus.cp0_addr == 9) m_count = bus.cp0_wdata;
        else                         m_count = m_count + 1;
        if (wr && bus.cp0_addr == 11) m_ip1 = 0;
        else if (hit)                 m_ip1 = 1;
        if (exc_entry) begin
            m_epc = epc_in; m_exccode = exc_code; m_status = m_status | 32'h2;
        end else if (eret) begin
            m_status = m_status & ~32'h2;
        end else if (wr) begin
            case (bus.cp0_addr)
                5'd11: m_compare = bus.cp0_wdata;
                5'd12: m_status  = bus.cp0_wdata & 32'h0000_0C03;
                5'd13: m_exccode = bus.cp0_wdata[6:2];
                5'd14: m_epc     = bus.cp0_wdata;
                default: ;
            endcase
        end
    endtask

    // One clock: compare every output against the model mid-cycle, then advance both.
    task automatic cyc();
        @(negedge clk);
        check("rdata", bus.cp0_rdata, m_read(bus.cp0_addr));
        check("int_kbd", 32'(int_kbd), 32'(m_ip0() && m_enabled(10)));
        check("int_cnt", 32'(int_cnt), 32'(m_ip1 && m_enabled(11)));
        check("epc_out", epc_out, m_epc);
        check("status_out", status_out, m_status);
        check("handler_addr", handler_addr, 32'h0000_0180);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = d;
        cyc();
        bus.cp0_we = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        #1;
        check(tag, bus.cp0_rdata, exp);
    endtask

    initial begin
        reset = 1'b1; exc_entry = 0; exc_code = 0; epc_in = 0; eret = 0; hw_int = 0;
        bus.cp0_we = 0; bus.cp0_addr = 0; bus.cp0_wdata = 0;
        m_status = 0; m_epc = 0; m_count = 0; m_compare = 0; m_exccode = 0; m_ip1 = 0;
        cyc(); cyc();
        reset = 1'b0;
        peek("reset_status", 12, 32'h0);
        peek("reset_count", 9, 32'h0);

        // Status writable fields only
        mtc0(12, 32'h0000_0C03);
        peek("status_c03", 12, 32'h0000_0C03);
        mtc0(12, 32'hFFFF_FFFF);
        peek("status_mask", 12, 32'h0000_0C03);

        // Keyboard interrupt, exception entry, eret
        mtc0(12, 32'h0000_0401);
        hw_int = 1'b1;
        cyc();
        check("kbd_1edge", 32'(int_kbd), 32'd0);
        cyc();
        check("kbd_2edge", 32'(int_kbd), 32'd1);
        exc_entry = 1; epc_in = 32'h40; exc_code = 0;
        cyc();
        exc_entry = 0;
        check("exc_epc", epc_out, 32'h40);
        peek("exc_cause", 13, 32'h400);
        check("exc_kbd_off", 32'(int_kbd), 32'd0);
        check("exc_exl", 32'(status_out[1]), 32'd1);
        eret = 1;
        cyc();
        eret = 0;
        check("eret_kbd_on", 32'(int_kbd), 32'd1);
        hw_int = 1'b0;

        // Timer match 11 edges after the Count write
        mtc0(12, 32'h0000_0801);
        mtc0(11, 32'd20);
        mtc0(9, 32'd10);
        for (int i = 1; i <= 10; i++) cyc();
        check("timer_early", 32'(int_cnt), 32'd0);
        cyc();
        check("timer_set", 32'(int_cnt), 32'd1);
        peek("timer_ip1", 13, 32'h800);
        mtc0(11, 32'd0);
        check("timer_clr", 32'(int_cnt), 32'd0);
        cyc(); cyc(); cyc();
        peek("timer_stays_clr", 13, 32'h0);

        // Count wrap
        mtc0(9, 32'hFFFF_FFFE);
        peek("count_fe", 9, 32'hFFFF_FFFE);
        cyc(); peek("count_ff", 9, 32'hFFFF_FFFF);
        cyc(); peek("count_0", 9, 32'h0);
        cyc(); peek("count_1", 9, 32'h1);

        // Priority: exc_entry over mtc0, exc_entry over eret
        exc_entry = 1; exc_code = 8; epc_in = 32'h100;
        bus.cp0_we = 1; bus.cp0_addr = 14; bus.cp0_wdata = 32'h200;
        cyc();
        exc_entry = 0; bus.cp0_we = 0;
        check("prio_epc", epc_out, 32'h100);
        peek("prio_exccode", 13, 32'h20);
        eret = 1;
        cyc();
        eret = 0;
        check("eret_exl0", 32'(status_out[1]), 32'd0);
        exc_entry = 1; eret = 1;
        cyc();
        exc_entry = 0; eret = 0;
        check("both_exl1", 32'(status_out[1]), 32'd1);

        // Reset with EXL=1 and IP1 pending
        mtc0(11, 32'd5);
        mtc0(9, 32'd3);
        cyc(); cyc(); cyc();
        peek("pre_reset_ip1", 13, 32'h0000_0820);
        reset = 1; bus.cp0_we = 1; bus.cp0_addr = 14; bus.cp0_wdata = 32'hDEAD;
        exc_entry = 1; epc_in = 32'h44;
        cyc();
        reset = 0; bus.cp0_we = 0; exc_entry = 0;
        check("rst_status", status_out, 32'h0);
        check("rst_epc", epc_out, 32'h0);
        check("rst_int_cnt", 32'(int_cnt), 32'd0);
        peek("rst_cause", 13, 32'h0);
        peek("rst_count", 9, 32'h0);
        cyc();
        peek("rst_count_1", 9, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [4:0] addrs [6];
            addrs[0] = 9; addrs[1] = 11; addrs[2] = 12; addrs[3] = 13; addrs[4] = 14;
            addrs[5] = 5'($urandom_range(0, 31));
            reset     = ($urandom_range(0, 199) == 0);
            exc_entry = ($urandom_range(0, 19) == 0);
            eret      = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 3);
            exc_code  = (r == 0) ? 5'd0 : (r == 1) ? 5'd8 : (r == 2) ? 5'd10 : 5'd12;
            epc_in    = $urandom;
            if ($urandom_range(0, 15) == 0) hw_int = ~hw_int;
            bus.cp0_we    = ($urandom_range(0, 3) == 0);
            bus.cp0_addr  = addrs[$urandom_range(0, 5)];
            bus.cp0_wdata = $urandom;
            if (bus.cp0_addr == 11 && $urandom_range(0, 1) == 1)
                bus.cp0_wdata = m_count + 32'($urandom_range(0, 12));
            else if (bus.cp0_addr == 12 && $urandom_range(0, 1) == 1)
                bus.cp0_wdata = 32'h0000_0C01;
            else if (bus.cp0_addr == 9 && $urandom_range(0, 1) == 1)
                bus.cp0_wdata = m_compare - 32'($urandom_range(0, 12));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
